// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB master between NUM_REQ requesters using
// round-robin priority. The winner's command is latched and held on the master
// interface until the transfer completes, then the winner gets a one-cycle ack.
// Optional feature macro: APB_ARB_LOCK_EN (adds req_lock; a locked owner keeps
// priority for the next arbitration).
module apb_req_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
`ifdef APB_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]               req_lock,
`endif
    output logic [NUM_REQ-1:0]               req_ack,
    output logic [DATA_WIDTH-1:0]            req_rdata,
    output logic                             busy,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             mst_start,
    output logic                             mst_write,
    output logic [ADDR_WIDTH-1:0]            mst_addr,
    output logic [DATA_WIDTH-1:0]            mst_wdata,
    input  logic [DATA_WIDTH-1:0]            mst_rdata,
    input  logic                             mst_done
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [IDW-1:0]          r_grant_id;
    logic [IDW-1:0]          r_last_grant;
    logic                    r_mst_start;
    logic                    r_mst_write;
    logic [ADDR_WIDTH-1:0]   r_mst_addr;
    logic [DATA_WIDTH-1:0]   r_mst_wdata;
    logic [DATA_WIDTH-1:0]   r_req_rdata;
    logic [NUM_REQ-1:0]      r_req_ack;
    logic                    r_busy;

    logic [IDW-1:0]          w_grant_nxt;
    logic [IDW-1:0]          w_last_nxt;
    logic                    w_start_nxt;
    logic                    w_write_nxt;
    logic [ADDR_WIDTH-1:0]   w_addr_nxt;
    logic [DATA_WIDTH-1:0]   w_wdata_nxt;
    logic [DATA_WIDTH-1:0]   w_rdata_nxt;
    logic [NUM_REQ-1:0]      w_ack_nxt;
    logic                    w_busy_nxt;

    logic                    w_found;
    logic [IDW-1:0]          w_sel;

`ifdef APB_ARB_LOCK_EN
    logic                    r_lock_hold;
    logic                    w_hold_nxt;
`endif

    // Round-robin pick: first pending request after last_grant, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
`ifdef APB_ARB_LOCK_EN
        if (r_lock_hold && req[r_grant_id]) begin
            w_found = 1'b1;
            w_sel   = r_grant_id;
        end
`endif
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req[(32'(r_last_grant) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_sel   = IDW'((32'(r_last_grant) + k) % NUM_REQ);
            end
        end
    end

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_last_nxt  = r_last_grant;
        w_start_nxt = 1'b0;
        w_write_nxt = r_mst_write;
        w_addr_nxt  = r_mst_addr;
        w_wdata_nxt = r_mst_wdata;
        w_rdata_nxt = r_req_rdata;
        w_ack_nxt   = '0;
`ifdef APB_ARB_LOCK_EN
        w_hold_nxt  = r_lock_hold;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef APB_ARB_LOCK_EN
                w_hold_nxt = 1'b0;
`endif
                if (w_found) begin
                    w_state_nxt = S_START;
                    w_grant_nxt = w_sel;
                    w_start_nxt = 1'b1;
                    w_write_nxt = req_write[w_sel];
                    w_addr_nxt  = req_addr[32'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
                    w_wdata_nxt = req_wdata[32'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mst_done) begin
                    w_state_nxt           = S_ACK;
                    w_rdata_nxt           = mst_rdata;
                    w_ack_nxt[r_grant_id] = 1'b1;
`ifndef APB_ARB_LOCK_EN
                    w_last_nxt            = r_grant_id;
`endif
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
`ifdef APB_ARB_LOCK_EN
                // A locked owner leaves last_grant untouched and keeps priority.
                if (req_lock[r_grant_id]) begin
                    w_hold_nxt = 1'b1;
                end else begin
                    w_last_nxt = r_grant_id;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Output and datapath registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_grant_id   <= '0;
            r_last_grant <= IDW'(NUM_REQ - 1);
            r_mst_start  <= 1'b0;
            r_mst_write  <= 1'b0;
            r_mst_addr   <= '0;
            r_mst_wdata  <= '0;
            r_req_rdata  <= '0;
            r_req_ack    <= '0;
            r_busy       <= 1'b0;
`ifdef APB_ARB_LOCK_EN
            r_lock_hold  <= 1'b0;
`endif
        end else begin
            r_grant_id   <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_mst_start  <= w_start_nxt;
            r_mst_write  <= w_write_nxt;
            r_mst_addr   <= w_addr_nxt;
            r_mst_wdata  <= w_wdata_nxt;
            r_req_rdata  <= w_rdata_nxt;
            r_req_ack    <= w_ack_nxt;
            r_busy       <= w_busy_nxt;
`ifdef APB_ARB_LOCK_EN
            r_lock_hold  <= w_hold_nxt;
`endif
        end
    end

    assign req_ack   = r_req_ack;
    assign req_rdata = r_req_rdata;
    assign busy      = r_busy;
    assign grant_id  = r_grant_id;
    assign mst_start = r_mst_start;
    assign mst_write = r_mst_write;
    assign mst_addr  = r_mst_addr;
    assign mst_wdata = r_mst_wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed bench for apb_req_arbiter with a small APB
// master stand-in (done three cycles after start, plus programmable waits).
module tb_apb_req_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic                PCLK;
    logic                PRESET;
    logic [NR-1:0]       req;
    logic [NR-1:0]       req_write;
    logic [NR*AW-1:0]    req_addr;
    logic [NR*DW-1:0]    req_wdata;
`ifdef APB_ARB_LOCK_EN
    logic [NR-1:0]       req_lock;
`endif
    logic [NR-1:0]       req_ack;
    logic [DW-1:0]       req_rdata;
    logic                busy;
    logic [1:0]          grant_id;
    logic                mst_start;
    logic                mst_write;
    logic [AW-1:0]       mst_addr;
    logic [DW-1:0]       mst_wdata;
    logic [DW-1:0]       mst_rdata;
    logic                mst_done;

    int                  n_checks;
    int                  n_fails;
    int                  tb_waits;
    int                  m_cnt;
    logic [DW-1:0]       slave_rdata;

    apb_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef APB_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ack   (req_ack),
        .req_rdata (req_rdata),
        .busy      (busy),
        .grant_id  (grant_id),
        .mst_start (mst_start),
        .mst_write (mst_write),
        .mst_addr  (mst_addr),
        .mst_wdata (mst_wdata),
        .mst_rdata (mst_rdata),
        .mst_done  (mst_done)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Master stand-in: done pulses 3 + tb_waits cycles after start is seen.
    initial begin
        mst_done  = 1'b0;
        mst_rdata = '0;
        m_cnt     = 0;
        forever begin
            @(posedge PCLK);
            #2;
            mst_done = 1'b0;
            if (PRESET) begin
                m_cnt = 0;
            end else begin
                if (m_cnt > 0) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        mst_done  = 1'b1;
                        mst_rdata = slave_rdata;
                    end
                end
                if (mst_start) m_cnt = 3 + tb_waits;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        step();
        step();
        PRESET = 1'b0;
    endtask

    task automatic wait_ack(input logic [AW-1:0] exp_addr, output int n, output int starts,
                            output int addr_bad, output logic [NR-1:0] ack);
        bit seen;
        n = 0; starts = 0; addr_bad = 0; ack = '0; seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            n++;
            if (mst_start) begin
                starts++;
                seen = 1'b1;
            end
            if (seen && mst_addr !== exp_addr) addr_bad++;
            if (req_ack != '0) begin
                ack = req_ack;
                break;
            end
        end
        if (ack == '0) check("ack_timeout", 64'(n), 64'(0));
    endtask

    initial begin
        int n, st, bad, cnt;
        logic [NR-1:0] ack;
        n_checks = 0; n_fails = 0; tb_waits = 0; slave_rdata = '0;
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
`ifdef APB_ARB_LOCK_EN
        req_lock = '0;
`endif
        for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 32'h100 + 32'(i) * 32'h10;

        do_reset();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ack", 64'(req_ack), 64'(0));
        check("rst_start", 64'(mst_start), 64'(0));
        check("rst_grant", 64'(grant_id), 64'(0));
        check("rst_addr", 64'(mst_addr), 64'(0));
        check("rst_rdata", 64'(req_rdata), 64'(0));

        // Write from requester 0, zero-wait slave, cycle by cycle.
        req[0] = 1'b1; req_write[0] = 1'b1;
        req_addr[0 +: AW] = 32'h10; req_wdata[0 +: DW] = 32'hA5A5A5A5;
        for (int c = 1; c <= 6; c++) begin
            step();
            check($sformatf("wr_start_c%0d", c), 64'(mst_start), 64'(c == 1));
            check($sformatf("wr_busy_c%0d", c), 64'(busy), 64'(c <= 5));
            check($sformatf("wr_ack_c%0d", c), 64'(req_ack), (c == 5) ? 64'h1 : 64'h0);
            check($sformatf("wr_addr_c%0d", c), 64'(mst_addr), 64'h10);
            check($sformatf("wr_wdata_c%0d", c), 64'(mst_wdata), 64'hA5A5A5A5);
            check($sformatf("wr_dir_c%0d", c), 64'(mst_write), 64'h1);
            if (c == 5) req[0] = 1'b0;
        end

        // Read from requester 2.
        slave_rdata = 32'hDEADBEEF;
        req[2] = 1'b1; req_write[2] = 1'b0; req_addr[2*AW +: AW] = 32'h24;
        wait_ack(32'h24, n, st, bad, ack);
        check("rd_ack", 64'(ack), 64'h4);
        check("rd_rdata", 64'(req_rdata), 64'hDEADBEEF);
        check("rd_grant", 64'(grant_id), 64'h2);
        check("rd_dir", 64'(mst_write), 64'h0);
        check("rd_latency", 64'(n), 64'(5));
        req[2] = 1'b0;
        step();

        // Round-robin with all four requesters pending.
        do_reset();
        slave_rdata = 32'h0;
        for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 32'h200 + 32'(i) * 32'h4;
        req = 4'b1111;
        for (int t = 0; t < 6; t++) begin
            wait_ack(32'h200 + 32'(t % 4) * 32'h4, n, st, bad, ack);
            cnt = $countones(ack);
            check($sformatf("rr_ack_t%0d", t), 64'(ack), 64'(1) << (t % 4));
            check($sformatf("rr_grant_t%0d", t), 64'(grant_id), 64'(t % 4));
            check($sformatf("rr_onehot_t%0d", t), 64'(cnt), 64'(1));
            check($sformatf("rr_starts_t%0d", t), 64'(st), 64'(1));
        end
        req = '0;
        step();

        // Five wait states on requester 1.
        tb_waits = 5;
        req[1] = 1'b1; req_addr[1*AW +: AW] = 32'h44;
        wait_ack(32'h44, n, st, bad, ack);
        check("ws_ack", 64'(ack), 64'h2);
        check("ws_latency", 64'(n), 64'(10));
        check("ws_starts", 64'(st), 64'(1));
        check("ws_addr_stable", 64'(bad), 64'(0));
        req[1] = 1'b0;
        tb_waits = 0;
        step();

        // Reset during WAIT drops the transfer; the re-issued request completes.
        req[3] = 1'b1; req_addr[3*AW +: AW] = 32'h30;
        step();
        step();
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        check("mr_busy", 64'(busy), 64'(0));
        check("mr_ack", 64'(req_ack), 64'(0));
        check("mr_start", 64'(mst_start), 64'(0));
        check("mr_addr", 64'(mst_addr), 64'(0));
        check("mr_grant", 64'(grant_id), 64'(0));
        wait_ack(32'h30, n, st, bad, ack);
        check("mr_reissue_ack", 64'(ack), 64'h8);
        check("mr_reissue_latency", 64'(n), 64'(5));
        check("mr_reissue_grant", 64'(grant_id), 64'h3);
        req[3] = 1'b0;
        step();

`ifdef APB_ARB_LOCK_EN
        // Locked owner keeps priority: grants 1,1,3.
        do_reset();
        req_addr[1*AW +: AW] = 32'h51; req_addr[3*AW +: AW] = 32'h53;
        req = 4'b1010; req_lock = 4'b0010;
        wait_ack(32'h51, n, st, bad, ack);
        check("lk_g0", 64'(ack), 64'h2);
        step();
        req_lock = '0;
        wait_ack(32'h51, n, st, bad, ack);
        check("lk_g1", 64'(ack), 64'h2);
        req[1] = 1'b0;
        wait_ack(32'h53, n, st, bad, ack);
        check("lk_g2", 64'(ack), 64'h8);
        req = '0;
        step();

        // Without lock: grants 1,3.
        do_reset();
        req = 4'b1010;
        wait_ack(32'h51, n, st, bad, ack);
        check("nl_g0", 64'(ack), 64'h2);
        wait_ack(32'h53, n, st, bad, ack);
        check("nl_g1", 64'(ack), 64'h8);
        req = '0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single APB master BFM between NUM_REQ independent requesters.
- Picks one pending request using round-robin priority.
- Drives the master's control interface (start pulse, direction, address, write data) and holds it stable for the whole APB transfer.
- On the master's transfer_done pulse, returns read data and a one-cycle acknowledge to the winning requester.

Parameters:
- NUM_REQ, 4: number of requesters; must be >= 2.
- ADDR_WIDTH, 32: APB address width; matches the master.
- DATA_WIDTH, 32: APB data width; matches the master.
- IDW, $clog2(NUM_REQ): derived localparam; width of grant index.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high; shared with the APB master.
- req  in  NUM_REQ  per-requester request level; held until its req_ack.
- req_write  in  NUM_REQ  per-requester direction, 1 = write.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data; same packing.
- req_ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- req_rdata  out  DATA_WIDTH  read data of the last completed transfer.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  IDW  index of the current or last owner.
- mst_start  out  1  to master start_transfer; one-cycle pulse.
- mst_write  out  1  to master write_read_n.
- mst_addr  out  ADDR_WIDTH  to master address.
- mst_wdata  out  DATA_WIDTH  to master write_data.
- mst_rdata  in  DATA_WIDTH  from master read_data.
- mst_done  in  1  from master transfer_done.

Behaviour:
- Reset (sync, PRESET=1 at edge): state=IDLE; all outputs 0; last_grant=NUM_REQ-1, so requester 0 wins first.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, ACK.
  - IDLE: if any req bit is high, select the first set bit searching last_grant+1, +2, ... with wrap-around. Latch that index into grant_id. Latch its req_write, req_addr and req_wdata into mst_write, mst_addr and mst_wdata. Go to START. If no req bit is high, stay in IDLE.
  - START: mst_start=1 for exactly this cycle; go to WAIT.
  - WAIT: mst_start=0. When mst_done=1, capture mst_rdata into req_rdata (also on writes), set last_grant=grant_id, and go to ACK. Otherwise stay in WAIT indefinitely; there is no timeout.
  - ACK: req_ack[grant_id]=1 for this cycle only; go to IDLE.
- mst_write, mst_addr and mst_wdata change only on the IDLE->START edge. They stay constant from START through ACK, because the master passes them to the bus combinationally in every state.
- Requester rule:
  - req must stay high until req_ack is seen.
  - The requester drops req, or presents a new command, in the cycle after req_ack.
  - Requests are never sampled during START, WAIT or ACK, so the ACK cycle cannot cause a double grant.
  - Changing a pending requester's command before it is granted is allowed; the value in the granting cycle is used.
- Latency with zero-wait slave: req high in cycle 0 -> mst_start in cycle 1 -> master SETUP in cycle 2, ACCESS in cycle 3 -> mst_done in cycle 4 -> req_ack in cycle 5 -> IDLE in cycle 6. Minimum issue-to-issue spacing is 6 cycles. Each PREADY wait state adds 1 cycle.
- mst_done while in IDLE, START or ACK: ignored; no ack is generated.
- req deasserted by the owner after grant: the transfer still completes and req_ack still pulses.
- Reset mid-transfer: the FSM returns to IDLE next cycle with outputs 0. The pending request is dropped with no ack, and the requester must re-issue it. The master is reset by the same signal.

Optional Feature:
- Macro: APB_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock, NUM_REQ wide.
  - If req_lock[grant_id]=1 in the ACK cycle, last_grant is not advanced, and the owner keeps priority 0 at the next IDLE arbitration when its req is high.
  - This allows back-to-back locked sequences.
  - If the owner's req is low in that IDLE cycle, normal round-robin applies.
- Undefined: port absent; pure round-robin.

Test Plan:
- Write: req[0]=1, write=1, addr=0x10, wdata=0xA5A5A5A5, zero-wait slave -> mst_start high only in cycle 1; mst_addr=0x10 and mst_wdata=0xA5A5A5A5 stable cycles 1-5; req_ack=0001 in cycle 5; busy low in cycle 6.
- Read: req[2]=1, write=0, addr=0x24, slave PRDATA=0xDEADBEEF -> req_rdata=0xDEADBEEF and req_ack=0100 in the same cycle; grant_id=2.
- Round-robin: req=1111 held, each requester re-raised after its ack -> grant order 0,1,2,3,0,1; no requester granted twice consecutively; exactly one ack per transfer.
- Wait states: PREADY low for 5 ACCESS cycles -> single mst_start pulse; mst_addr unchanged throughout; req_ack 5 cycles later than the zero-wait case.
- Reset: PRESET=1 for 1 cycle during WAIT -> next cycle state IDLE, all outputs 0, no req_ack; the re-issued request completes normally.
- Lock (APB_ARB_LOCK_EN): req[1] and req[3] high, req_lock[1]=1 for the first transfer -> grants 1,1,3; with req_lock=0 -> grants 1,3.
